// File: rtl/aes_key_bank_pkg.sv
// Shared definitions for the AES-128 key bank:
// round count, round-key type, FSM states, rcon and S-box tables.
package aes_key_bank_pkg;

   localparam int AES_NR = 10;

   typedef logic [127:0] round_key_t;

   typedef enum logic {
      IDLE,
      EXPAND
   } kb_state_e;

   // Round constant for expansion round r (1..10); 0 elsewhere.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,
      8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,
      8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,
      8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,
      8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,
      8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,
      8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,
      8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,
      8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,
      8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,
      8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,
      8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,
      8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,
      8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,
      8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,
      8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,
      8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

endpackage

// File: rtl/aes_key_round.sv
// One combinational AES-128 key-expansion step, plus the S-box.
// aes_key_round: key_in (rk[r-1]), rcon -> key_out (rk[r]).
module aes_sbox
   import aes_key_bank_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);

   assign y = SBOX[a];

endmodule

module aes_key_round
   import aes_key_bank_pkg::*;
(
   input  round_key_t key_in,
   input  logic [7:0] rcon,
   output round_key_t key_out
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot, sub;
   logic [31:0] n0, n1, n2, n3;

   // Word 0 is the most significant word.
   assign {w0, w1, w2, w3} = key_in;
   assign rot = {w3[23:0], w3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sb
      aes_sbox u_sbox (
         .a (rot[8*i +: 8]),
         .y (sub[8*i +: 8])
      );
   end

   assign n0 = w0 ^ sub ^ {rcon, 24'h0};
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_bank.sv
// Multi-slot AES-128 round-key store with a one-round-per-cycle expander.
// Ports: load (valid/ready/slot/key), invalidate, halt, busy,
// slot_valid, and NUM_RD combinational read ports (slot/round -> key/hit).
module aes_key_bank
   import aes_key_bank_pkg::*;
#(
   parameter  int NUM_SLOTS = 4,
   parameter  int NUM_RD    = 10,
   localparam int SLOT_W    = $clog2(NUM_SLOTS > 1 ? NUM_SLOTS : 2)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     halt,
   input  logic                     load_valid,
   output logic                     load_ready,
   input  logic [SLOT_W-1:0]        load_slot,
   input  logic [127:0]             load_key,
   input  logic                     inv_valid,
   input  logic [SLOT_W-1:0]        inv_slot,
   output logic                     busy,
   output logic [NUM_SLOTS-1:0]     slot_valid,
   input  logic [NUM_RD*SLOT_W-1:0] rd_slot,
   input  logic [NUM_RD*4-1:0]      rd_round,
   output logic [NUM_RD*128-1:0]    rd_key,
   output logic [NUM_RD-1:0]        rd_hit
);

   function automatic logic in_range(input logic [SLOT_W-1:0] s);
      return int'(s) < NUM_SLOTS;
   endfunction

   kb_state_e            state, state_n;
   logic [3:0]           rnd, rnd_n, rnd_prev;
   logic [SLOT_W-1:0]    cur, cur_n;
   logic [NUM_SLOTS-1:0] vld, vld_n;
   logic                 ld_acc, inv_ok, wr_en;
   round_key_t           nxt_key;

   round_key_t rk [NUM_SLOTS][AES_NR+1];

   assign load_ready = rst_n && (state == IDLE) && in_range(load_slot);
   assign ld_acc     = load_valid && load_ready;
   assign inv_ok     = inv_valid && in_range(inv_slot);
   assign busy       = (state == EXPAND);
   assign slot_valid = vld;

   // Keeps the expander's read index in range while idle.
   assign rnd_prev = (rnd == 4'd0) ? 4'd0 : rnd - 4'd1;

   aes_key_round u_round (
      .key_in  (rk[cur][rnd_prev]),
      .rcon    (rcon(rnd)),
      .key_out (nxt_key)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         rnd   <= '0;
         cur   <= '0;
         vld   <= '0;
      end else begin
         state <= state_n;
         rnd   <= rnd_n;
         cur   <= cur_n;
         vld   <= vld_n;
      end
   end

   always_comb begin
      state_n = state;
      rnd_n   = rnd;
      cur_n   = cur;
      vld_n   = vld;
      wr_en   = 1'b0;
      if (inv_ok)
         vld_n[inv_slot] = 1'b0;
      case (state)
         IDLE: begin
            // An accepted load overrides a same-cycle invalidate.
            if (ld_acc) begin
               vld_n[load_slot] = 1'b0;
               cur_n   = load_slot;
               rnd_n   = 4'd1;
               state_n = EXPAND;
            end
         end
         EXPAND: begin
            if (inv_ok && inv_slot == cur) begin
               state_n = IDLE;
               rnd_n   = '0;
            end else if (!halt) begin
               wr_en = 1'b1;
               rnd_n = rnd + 4'd1;
               if (rnd == 4'(AES_NR)) begin
                  vld_n[cur] = 1'b1;
                  state_n    = IDLE;
                  rnd_n      = '0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Key storage carries no reset; reads are gated by slot_valid.
   always_ff @(posedge clk) begin
      if (ld_acc)
         rk[load_slot][0] <= load_key;
      if (wr_en)
         rk[cur][rnd] <= nxt_key;
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [SLOT_W-1:0] s;
      logic [3:0]        r;
      logic              hit;
      round_key_t        key;

      assign s = rd_slot[p*SLOT_W +: SLOT_W];
      assign r = rd_round[p*4 +: 4];

      always_comb begin
         hit = 1'b0;
         key = '0;
         if (in_range(s) && r <= 4'(AES_NR))
            hit = vld[s];
         if (hit)
            key = rk[s][r];
      end

      assign rd_hit[p]           = hit;
      assign rd_key[p*128 +: 128] = key;
   end

endmodule
